// File: rtl/csc_frame_arbiter_pkg.sv
// Shared types and constants for the frame-granular CSC arbiter.
package csc_frame_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WAIT_SOF = 2'd1,
      ACTIVE   = 2'd2,
      DRAIN    = 2'd3
   } arb_state_t;

   localparam logic SRC0 = 1'b0;
   localparam logic SRC1 = 1'b1;

   // Converter latency and the drain counter width it implies.
   localparam int LAT_DEFAULT = 5;
   localparam int DRAIN_CNT_W = $clog2(LAT_DEFAULT + 2);

   // One pixel beat with its timing.
   typedef struct packed {
      logic       vs;
      logic       hs;
      logic       de;
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
   } pix_t;

   // Tag travelling alongside the converter pipeline.
   typedef struct packed {
      logic src;
      logic fwd;
   } tag_t;

   function automatic logic [1:0] src_onehot(input logic src);
      return (src == SRC1) ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/csc_tag_pipe.sv
// Delay line carrying {src, fwd} so the tag lands with the converter output.
module csc_tag_pipe
   import csc_frame_arbiter_pkg::*;
#(
   parameter int DEPTH = LAT_DEFAULT + 1
) (
   input  logic clk,
   input  logic rst_b,
   input  tag_t tag_in,
   output tag_t tag_out
);

   tag_t [DEPTH-1:0] vld_pipe;

   // Plain shift register; stage 0 is loaded alongside the cv_* registers.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) vld_pipe <= '0;
      else        vld_pipe <= {vld_pipe[DEPTH-2:0], tag_in};
   end

   assign tag_out = vld_pipe[DEPTH-1];

endmodule

// File: rtl/csc_frame_arbiter.sv
// Grants one shared RGB->YCbCr converter to one of two sources per frame.
module csc_frame_arbiter
   import csc_frame_arbiter_pkg::*;
#(
   parameter int LAT = LAT_DEFAULT
) (
   input  logic       clk,
   input  logic       rst_b,
   input  logic [1:0] req,
   input  logic       s0_vs,
   input  logic       s0_hs,
   input  logic       s0_de,
   input  logic [7:0] s0_r,
   input  logic [7:0] s0_g,
   input  logic [7:0] s0_b,
   input  logic       s1_vs,
   input  logic       s1_hs,
   input  logic       s1_de,
   input  logic [7:0] s1_r,
   input  logic [7:0] s1_g,
   input  logic [7:0] s1_b,
   output logic [1:0] gnt,
   output logic [1:0] frame_done,
   output logic       cv_vs,
   output logic       cv_hs,
   output logic       cv_de,
   output logic [7:0] cv_r,
   output logic [7:0] cv_g,
   output logic [7:0] cv_b,
   input  logic       cv_de_ret,
   output logic       tag_src,
   output logic       tag_vld
);

   localparam int              CNT_W   = $clog2(LAT + 2);
   localparam logic [CNT_W-1:0] CNT_END = CNT_W'(LAT);

   arb_state_t       state, state_nxt;
   logic [1:0]       gnt_nxt;
   logic             last_gnt, last_gnt_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             vs0_d, vs1_d;
   logic             rise0, rise1, rise_sel;
   logic             sel, winner, fwd;
   pix_t             pix0, pix1, pix_sel, cv_q;
   tag_t             tag_in, tag_out;

   // vs edge detectors; cleared by reset so a held-high vs cannot fake a SOF.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         vs0_d <= 1'b0;
         vs1_d <= 1'b0;
      end else begin
         vs0_d <= s0_vs;
         vs1_d <= s1_vs;
      end
   end

   assign rise0    = s0_vs & ~vs0_d;
   assign rise1    = s1_vs & ~vs1_d;
   assign sel      = gnt[1];
   assign rise_sel = sel ? rise1 : rise0;
   // Both requesting: the source not served last wins.
   assign winner   = (req == 2'b11) ? ~last_gnt : (req[1] ? SRC1 : SRC0);

   assign pix0    = '{vs: s0_vs, hs: s0_hs, de: s0_de, r: s0_r, g: s0_g, b: s0_b};
   assign pix1    = '{vs: s1_vs, hs: s1_hs, de: s1_de, r: s1_r, g: s1_g, b: s1_b};
   assign pix_sel = sel ? pix1 : pix0;

   // Arbiter state register.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         state    <= IDLE;
         gnt      <= 2'b00;
         last_gnt <= SRC1;
         cnt      <= '0;
      end else begin
         state    <= state_nxt;
         gnt      <= gnt_nxt;
         last_gnt <= last_gnt_nxt;
         cnt      <= cnt_nxt;
      end
   end

   // Next state, forwarding decision and end-of-drain pulse.
   always_comb begin
      state_nxt    = state;
      gnt_nxt      = gnt;
      last_gnt_nxt = last_gnt;
      cnt_nxt      = cnt;
      fwd          = 1'b0;
      frame_done   = 2'b00;
      case (state)
         IDLE: begin
            if (|req) begin
               gnt_nxt   = src_onehot(winner);
               state_nxt = WAIT_SOF;
            end
         end
         WAIT_SOF: begin
            // The SOF cycle itself is the first forwarded beat.
            if (rise_sel) begin
               fwd       = 1'b1;
               state_nxt = ACTIVE;
            end
         end
         ACTIVE: begin
            // The next rise closes the frame and is not forwarded.
            if (rise_sel) begin
               cnt_nxt   = '0;
               state_nxt = DRAIN;
            end else begin
               fwd = 1'b1;
            end
         end
         DRAIN: begin
            if (cnt == CNT_END) begin
               frame_done   = gnt;
               last_gnt_nxt = sel;
               gnt_nxt      = 2'b00;
               cnt_nxt      = '0;
               state_nxt    = IDLE;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Converter input register: granted source or zeros.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) cv_q <= '0;
      else        cv_q <= fwd ? pix_sel : '0;
   end

   assign cv_vs = cv_q.vs;
   assign cv_hs = cv_q.hs;
   assign cv_de = cv_q.de;
   assign cv_r  = cv_q.r;
   assign cv_g  = cv_q.g;
   assign cv_b  = cv_q.b;

   assign tag_in = '{src: sel, fwd: fwd};

   csc_tag_pipe #(.DEPTH(LAT + 1)) u_tag_pipe (
      .clk     (clk),
      .rst_b   (rst_b),
      .tag_in  (tag_in),
      .tag_out (tag_out)
   );

   assign tag_src = tag_out.src;
   assign tag_vld = tag_out.fwd & cv_de_ret;

endmodule

// File: tb/tb_csc_frame_arbiter.sv
// Randomized bench for csc_frame_arbiter with a frame-level reference model.
module tb_csc_frame_arbiter;

   localparam int LAT   = 5;
   localparam int H_ACT = 8;
   localparam int H_TOT = 12;
   localparam int V_ACT = 4;
   localparam int V_TOT = 6;
   localparam int FTOT  = H_TOT * V_TOT;
   localparam int MAXC  = 2100;

   logic       clk = 1'b0;
   logic       rst_b;
   logic [1:0] req;
   logic       s0_vs, s0_hs, s0_de, s1_vs, s1_hs, s1_de;
   logic [7:0] s0_r, s0_g, s0_b, s1_r, s1_g, s1_b;
   logic [1:0] gnt, frame_done;
   logic       cv_vs, cv_hs, cv_de;
   logic [7:0] cv_r, cv_g, cv_b;
   logic       cv_de_ret, tag_src, tag_vld;
   logic [LAT-1:0] de_sr = '0;

   int nvec = 0;
   int nerr = 0;
   int tick = 0;
   int off[2];
   bit white;

   logic [1:0]  req_plan[MAXC];
   logic [1:0]  req_h[MAXC];
   bit          vs_h[2][MAXC];
   bit          hs_h[2][MAXC];
   bit          de_h[2][MAXC];
   logic [7:0]  r_h[2][MAXC];
   logic [7:0]  g_h[2][MAXC];
   logic [7:0]  b_h[2][MAXC];
   logic [32:0] obs_h[MAXC];
   logic [32:0] exp_h[MAXC+16];

   always #5 clk = ~clk;

   // Stand-in for the converter: de_out is cv_de delayed by LAT.
   always @(posedge clk) de_sr <= {de_sr[LAT-2:0], cv_de};
   assign cv_de_ret = de_sr[LAT-1];

   csc_frame_arbiter #(.LAT(LAT)) dut (
      .clk(clk), .rst_b(rst_b), .req(req),
      .s0_vs(s0_vs), .s0_hs(s0_hs), .s0_de(s0_de), .s0_r(s0_r), .s0_g(s0_g), .s0_b(s0_b),
      .s1_vs(s1_vs), .s1_hs(s1_hs), .s1_de(s1_de), .s1_r(s1_r), .s1_g(s1_g), .s1_b(s1_b),
      .gnt(gnt), .frame_done(frame_done),
      .cv_vs(cv_vs), .cv_hs(cv_hs), .cv_de(cv_de), .cv_r(cv_r), .cv_g(cv_g), .cv_b(cv_b),
      .cv_de_ret(cv_de_ret), .tag_src(tag_src), .tag_vld(tag_vld)
   );

   // Drive both free-running raster sources for one cycle; record if k >= 0.
   task automatic drive(input logic [1:0] rq, input int k);
      bit v[2], h[2], d[2];
      logic [23:0] rgb[2];
      int pos, line, px;
      for (int n = 0; n < 2; n++) begin
         pos  = (tick + off[n]) % FTOT;
         line = pos / H_TOT;
         px   = pos % H_TOT;
         v[n] = (line == V_ACT);
         h[n] = (px >= H_ACT) && (px < H_ACT + 2);
         d[n] = (line < V_ACT) && (px < H_ACT);
         rgb[n] = white ? 24'hffffff : 24'($urandom);
         if (k >= 0) begin
            vs_h[n][k] = v[n]; hs_h[n][k] = h[n]; de_h[n][k] = d[n];
            r_h[n][k] = rgb[n][23:16]; g_h[n][k] = rgb[n][15:8]; b_h[n][k] = rgb[n][7:0];
         end
      end
      s0_vs = v[0]; s0_hs = h[0]; s0_de = d[0];
      {s0_r, s0_g, s0_b} = rgb[0];
      s1_vs = v[1]; s1_hs = h[1]; s1_de = d[1];
      {s1_r, s1_g, s1_b} = rgb[1];
      req = rq;
      if (k >= 0) req_h[k] = rq;
      tick++;
   endtask

   task automatic reset_hold(input int m);
      for (int i = 0; i < m; i++) begin
         @(negedge clk);
         rst_b = 1'b0;
         drive(2'b00, -1);
      end
   endtask

   // Release reset at the first negedge, then record outputs and apply req_plan.
   task automatic run(input int n);
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         obs_h[k] = {gnt, frame_done, cv_vs, cv_hs, cv_de, cv_r, cv_g, cv_b, tag_vld, tag_src};
         rst_b = 1'b1;
         drive(req_plan[k], k);
      end
   endtask

   function automatic bit rise_at(input int w, input int j);
      return vs_h[w][j] && ((j == 0) ? 1'b1 : !vs_h[w][j-1]);
   endfunction

   // Frame-level model: grant -> next rise of winner opens the window, the
   // following rise closes it, drain of LAT+1 then back to idle.
   function automatic void build_model(input int n);
      int k, s, e, w;
      bit last;
      logic [1:0] oh;
      for (int j = 0; j < n + LAT + 3; j++) exp_h[j] = '0;
      k = 0;
      last = 1'b1;
      while (k < n) begin
         if (req_h[k] == 2'b00) begin
            k++;
            continue;
         end
         w  = (req_h[k] == 2'b11) ? (last ? 0 : 1) : (req_h[k][1] ? 1 : 0);
         oh = (w == 1) ? 2'b10 : 2'b01;
         s = k + 1;
         while (s < n && !rise_at(w, s)) s++;
         e = s + 1;
         while (e < n && !rise_at(w, e)) e++;
         for (int j = k + 1; j <= e + LAT + 1 && j < n; j++) exp_h[j][32:31] = oh;
         for (int j = s; j < e && j < n; j++) begin
            exp_h[j+1][28:2] = {vs_h[w][j], hs_h[w][j], de_h[w][j], r_h[w][j], g_h[w][j], b_h[w][j]};
            exp_h[j+LAT+1][1] = de_h[w][j];
            exp_h[j+LAT+1][0] = de_h[w][j] & (w == 1);
         end
         if (e < n) exp_h[e+LAT+1][30:29] = oh;
         last = (w == 1);
         k = e + LAT + 2;
      end
   endfunction

   function automatic void plan_const(input logic [1:0] rq);
      for (int k = 0; k < MAXC; k++) req_plan[k] = rq;
   endfunction

   function automatic void align0();
      off[0] = (FTOT - (tick % FTOT)) % FTOT;
   endfunction

   task automatic test_reset();
      logic [32:0] o;
      rst_b = 1'b0;
      off[0] = 0; off[1] = 0; white = 1'b0;
      reset_hold(3);
      #1;
      o = {gnt, frame_done, cv_vs, cv_hs, cv_de, cv_r, cv_g, cv_b, tag_vld, tag_src};
      nvec++;
      if (o !== 33'h0) begin nerr++; $display("FAIL reset_state: got %h want 0", o); end
   endtask

   task automatic test_single();
      int n, fd_at, gnt_at, tv, fdc;
      n = 280; white = 1'b1;
      reset_hold(3); align0(); off[1] = $urandom_range(0, FTOT-1); plan_const(2'b01);
      run(n); build_model(n);
      fd_at = -1; gnt_at = -1; tv = 0; fdc = 0;
      for (int k = 0; k < n; k++) begin
         logic [32:0] o;
         o = obs_h[k];
         if (!exp_h[k][1]) o[0] = 1'b0;
         nvec++;
         if (o !== exp_h[k]) begin nerr++; $display("FAIL single cyc %0d: got %h want %h", k, o, exp_h[k]); end
         if (gnt_at < 0 && obs_h[k][32:31] == 2'b01) gnt_at = k;
         if (obs_h[k][30:29] == 2'b01) begin fdc++; if (fd_at < 0) fd_at = k; end
         if (obs_h[k][1] && !obs_h[k][0]) tv++;
      end
      nvec++; if (gnt_at !== 1) begin nerr++; $display("FAIL single_gnt_latency: got %0d want 1", gnt_at); end
      nvec++; if (fd_at !== V_ACT*H_TOT + FTOT + LAT + 1) begin nerr++; $display("FAIL single_done_time: got %0d want %0d", fd_at, V_ACT*H_TOT + FTOT + LAT + 1); end
      nvec++; if (tv !== 2*H_ACT*V_ACT) begin nerr++; $display("FAIL single_tag_cycles: got %0d want %0d", tv, 2*H_ACT*V_ACT); end
      nvec++; if (fdc !== 2) begin nerr++; $display("FAIL single_every_other: got %0d want 2", fdc); end
      white = 1'b0;
   endtask

   task automatic test_contention();
      int n, cnt;
      logic [1:0] prev, seq[3];
      n = 600;
      reset_hold(3); off[0] = $urandom_range(0, FTOT-1); off[1] = $urandom_range(0, FTOT-1);
      plan_const(2'b11);
      run(n); build_model(n);
      for (int k = 0; k < n; k++) begin
         logic [32:0] o;
         o = obs_h[k];
         if (!exp_h[k][1]) o[0] = 1'b0;
         nvec++;
         if (o !== exp_h[k]) begin nerr++; $display("FAIL contention cyc %0d: got %h want %h", k, o, exp_h[k]); end
      end
      seq[0] = 2'b00; seq[1] = 2'b00; seq[2] = 2'b00; prev = 2'b00; cnt = 0;
      for (int k = 0; k < n; k++) begin
         if (obs_h[k][32:31] != 2'b00 && obs_h[k][32:31] != prev && cnt < 3) begin
            seq[cnt] = obs_h[k][32:31]; cnt++;
         end
         prev = obs_h[k][32:31];
      end
      nvec++; if (seq[0] !== 2'b01) begin nerr++; $display("FAIL contention_grant0: got %b want 01", seq[0]); end
      nvec++; if (seq[1] !== 2'b10) begin nerr++; $display("FAIL contention_grant1: got %b want 10", seq[1]); end
      nvec++; if (seq[2] !== 2'b01) begin nerr++; $display("FAIL contention_grant2: got %b want 01", seq[2]); end
   endtask

   task automatic test_drop();
      int n, ts1;
      n = 400;
      reset_hold(3); off[0] = $urandom_range(0, FTOT-1); off[1] = $urandom_range(0, FTOT-1);
      plan_const(2'b01);
      run(n); build_model(n);
      ts1 = 0;
      for (int k = 0; k < n; k++) begin
         logic [32:0] o;
         o = obs_h[k];
         if (!exp_h[k][1]) o[0] = 1'b0;
         nvec++;
         if (o !== exp_h[k]) begin nerr++; $display("FAIL drop cyc %0d: got %h want %h", k, o, exp_h[k]); end
         if (obs_h[k][0] !== 1'b0) ts1++;
      end
      nvec++; if (ts1 !== 0) begin nerr++; $display("FAIL drop_tag_src: got %0d cycles with tag_src!=0 want 0", ts1); end
   endtask

   task automatic test_req_drop();
      int n, tv, fdc;
      n = 200;
      reset_hold(3); align0(); off[1] = $urandom_range(0, FTOT-1);
      for (int k = 0; k < MAXC; k++) req_plan[k] = (k < 96) ? 2'b01 : 2'b00;
      run(n); build_model(n);
      tv = 0; fdc = 0;
      for (int k = 0; k < n; k++) begin
         logic [32:0] o;
         o = obs_h[k];
         if (!exp_h[k][1]) o[0] = 1'b0;
         nvec++;
         if (o !== exp_h[k]) begin nerr++; $display("FAIL req_drop cyc %0d: got %h want %h", k, o, exp_h[k]); end
         if (obs_h[k][1] === 1'b1) tv++;
         if (obs_h[k][30:29] === 2'b01) fdc++;
      end
      nvec++; if (tv !== H_ACT*V_ACT) begin nerr++; $display("FAIL req_drop_tag_cycles: got %0d want %0d", tv, H_ACT*V_ACT); end
      nvec++; if (fdc !== 1) begin nerr++; $display("FAIL req_drop_done: got %0d want 1", fdc); end
   endtask

   task automatic test_reset_mid();
      int n, fr, early;
      logic [32:0] o;
      n = 86;
      reset_hold(3); align0(); off[1] = $urandom_range(0, FTOT-1); plan_const(2'b01);
      run(n); build_model(n);
      for (int k = 0; k < n; k++) begin
         o = obs_h[k];
         if (!exp_h[k][1]) o[0] = 1'b0;
         nvec++;
         if (o !== exp_h[k]) begin nerr++; $display("FAIL reset_mid_pre cyc %0d: got %h want %h", k, o, exp_h[k]); end
      end
      @(negedge clk);
      rst_b = 1'b0;
      drive(2'b01, -1);
      #1;
      o = {gnt, frame_done, cv_vs, cv_hs, cv_de, cv_r, cv_g, cv_b, tag_vld, tag_src};
      nvec++;
      if (o !== 33'h0) begin nerr++; $display("FAIL reset_mid_clear: got %h want 0", o); end
      reset_hold(2);
      n = 250;
      run(n); build_model(n);
      fr = 0;
      while (fr < n - 1 && !rise_at(0, fr)) fr++;
      early = 0;
      for (int k = 0; k < n; k++) begin
         o = obs_h[k];
         if (!exp_h[k][1]) o[0] = 1'b0;
         nvec++;
         if (o !== exp_h[k]) begin nerr++; $display("FAIL reset_mid_post cyc %0d: got %h want %h", k, o, exp_h[k]); end
         if (k <= fr && obs_h[k][26] !== 1'b0) early++;
      end
      nvec++; if (early !== 0) begin nerr++; $display("FAIL reset_mid_partial: got %0d forwarded beats want 0", early); end
   endtask

   task automatic test_coincide();
      int n, early;
      n = 250;
      reset_hold(3); align0(); off[1] = $urandom_range(0, FTOT-1);
      for (int k = 0; k < MAXC; k++) req_plan[k] = (k < V_ACT*H_TOT) ? 2'b00 : 2'b01;
      run(n); build_model(n);
      early = 0;
      for (int k = 0; k < n; k++) begin
         logic [32:0] o;
         o = obs_h[k];
         if (!exp_h[k][1]) o[0] = 1'b0;
         nvec++;
         if (o !== exp_h[k]) begin nerr++; $display("FAIL coincide cyc %0d: got %h want %h", k, o, exp_h[k]); end
         if (k <= V_ACT*H_TOT + FTOT && obs_h[k][26] !== 1'b0) early++;
      end
      nvec++; if (early !== 0) begin nerr++; $display("FAIL coincide_partial: got %0d forwarded beats want 0", early); end
   endtask

   task automatic test_random();
      int n;
      logic [1:0] cur;
      n = 2000;
      reset_hold(3); off[0] = $urandom_range(0, FTOT-1); off[1] = $urandom_range(0, FTOT-1);
      cur = 2'b00;
      for (int k = 0; k < MAXC; k++) begin
         if (k % 40 == 0) cur = 2'($urandom_range(0, 3));
         req_plan[k] = cur;
      end
      run(n); build_model(n);
      for (int k = 0; k < n; k++) begin
         logic [32:0] o;
         o = obs_h[k];
         if (!exp_h[k][1]) o[0] = 1'b0;
         nvec++;
         if (o !== exp_h[k]) begin nerr++; $display("FAIL random cyc %0d: got %h want %h", k, o, exp_h[k]); end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_contention();
      test_drop();
      test_req_drop();
      test_reset_mid();
      test_coincide();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule

// File: doc/csc_frame_arbiter.md
# csc_frame_arbiter

Frame-granular arbiter that shares one BT.709 RGB-to-YCbCr converter (fixed 5-clock latency) between two RGB video sources. It grants the converter to one source per frame in round-robin order. It gates the granted stream into the converter and switches sources only at frame boundaries. After each frame it flushes the converter pipeline and emits a source tag aligned with the converter output.

## Interface
- LAT, 5, converter latency in clocks, input sync/data to output sync/data.
- clk  in  1  clock.
- rst_b  in  1  reset, asynchronous, active-low.
- req  in  2  per-source service request, level; req[n] high means source n wants its next frame converted.
- s0_vs, s0_hs, s0_de  in  1 each  source 0 timing; vs is active-high.
- s0_r, s0_g, s0_b  in  8 each  source 0 pixel.
- s1_vs, s1_hs, s1_de, s1_r, s1_g, s1_b  in  1/1/1/8/8/8  source 1, same meaning as source 0.
- gnt  out  2  one-hot grant, 2'b00 when idle.
- frame_done  out  2  one-cycle pulse on the bit of the source whose frame has fully left the converter.
- cv_vs, cv_hs, cv_de  out  1 each  registered timing to the converter.
- cv_r, cv_g, cv_b  out  8 each  registered pixel to the converter.
- cv_de_ret  in  1  de_out returned from the converter.
- tag_src  out  1  source id aligned with converter output.
- tag_vld  out  1  high when converter output belongs to a granted frame; equals the tagged cv_de delayed by LAT.

## Operation
- Per-source vs rising-edge detect: vs_d registers, reset 0; `rise_n = sn_vs & ~vsn_d`.
- FSM states: IDLE, WAIT_SOF, ACTIVE, DRAIN.
  - IDLE: no req → stay. Otherwise pick the winner and set gnt, → WAIT_SOF.
  - Winner with one requester: that source.
  - Winner with both requesting: the source not granted last; last_gnt resets to 1, so source 0 wins first.
  - WAIT_SOF: on rise of the granted source → ACTIVE. The rising cycle's vs/hs/de/rgb are forwarded.
  - ACTIVE: forward the granted source every cycle. On the next rise of the granted source (frame end) → DRAIN. That rising cycle is not forwarded. req deasserting mid-frame does not abort; the frame completes.
  - DRAIN: count LAT+1 cycles with all cv_* at 0. At count end, pulse frame_done[granted], update last_gnt, clear gnt, → IDLE.
- Forwarding: cv_* <= selected source when in ACTIVE, or when in WAIT_SOF with the granted rise. Otherwise cv_* <= 0.
- Tag pipeline: a LAT+1-deep shift register of {src, fwd}.
  - tag_src = delayed src.
  - tag_vld = delayed fwd & cv_de_ret.
- req of a non-granted source is ignored until IDLE.
- No sources are buffered. A non-granted source's frame is dropped.

## Timing
- Reset values: gnt=0, frame_done=0, all cv_*=0, tag_src=0, tag_vld=0, FSM=IDLE, DRAIN counter=0, tag pipe=0, last_gnt=1.
- req to gnt: 1 clock (IDLE registered decision).
- Source pin to cv_*: 1 clock.
- Source pin to converter output: LAT+1 clocks.
- tag_src/tag_vld are valid in the same cycle as the converter's y/cb/cr.
- frame_done fires LAT+1 clocks after the end-of-frame rise is detected. By then the last forwarded pixel has exited the converter.
- Back-to-back frames of one source with the other idle: IDLE→WAIT_SOF costs 1 clock. Re-granting the same source waits for its following frame, so at most every other frame of a single source is converted.
- Reset mid-frame: all outputs return to their reset values immediately. After release the arbiter waits in IDLE, and a partial frame is never forwarded.
- Reset while rise coincides: the edge detector clears, so no false SOF occurs after release.

## Structure
- Shared package: state encoding (IDLE/WAIT_SOF/ACTIVE/DRAIN), SRC0/SRC1 ids, default LAT=5, DRAIN counter width clog2(LAT+2).
- One natural sub-module: csc_tag_pipe, a parameterised LAT+1-deep shift register carrying {src, fwd}, reset to 0.
- Everything else is inline: FSM, mux, edge detectors.
- The top level instantiating the arbiter alongside the converter is outside this block.

## Test plan
- Single requester: req=2'b01, src0 frames of 4 lines × 8 pixels with rgb=(255,255,255). Required: gnt=2'b01 one clock later; cv_de matches s0_de delayed by 1; tag_vld high for 32 cycles with tag_src=0; frame_done=2'b01 pulses 6 clocks after the next s0_vs rise.
- Contention: req=2'b11 from reset. Required: src0 is granted first, then src1 after frame_done[0], then src0 again. Grants alternate 01,10,01.
- Drop: src1 is active while src0 is granted. Required: cv_* never carries src1 data, and tag_src stays 0 throughout.
- Mid-frame req drop: req[0] falls halfway through the frame. Required: the frame still completes, with all 32 tag_vld cycles and a frame_done pulse.
- Reset mid-ACTIVE: assert rst_b=0 for 3 clocks during pixel 10. Required: cv_*, gnt and tag_* are 0 in the cycle rst_b falls. After release with req=01, no forwarding occurs before the next s0_vs rise.
- vs rising in the same cycle gnt is set: the rise is taken by WAIT_SOF only on the following rise. Required: no partial frame is forwarded.
